// File: rtl/stream_demux.sv
// Registered 1-to-N packet demultiplexer with valid/ready on every port.
// Routes each packet by its first beat to one channel or broadcasts it to all;
// packets aimed at a missing channel are swallowed and counted.
module stream_demux #(
  parameter int WIDTH = 8,
  parameter int N     = 8,
  parameter int SW    = 3,
  parameter int CW    = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic [SW-1:0]    in_sel,
  input  logic             in_bcast,
  output logic [N-1:0]     out_valid,
  input  logic [N-1:0]     out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [CW-1:0]    drop_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    DROP
  } state_e;

  localparam logic [SW:0]  NUM_CH = (SW + 1)'(N);
  localparam logic [N-1:0] ALL_CH = {N{1'b1}};

  state_e           state_q, state_d;
  logic [N-1:0]     rmask_q, rmask_d;
  logic [N-1:0]     pend_q, pend_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;
  logic [CW-1:0]    drop_cnt_q, drop_cnt_d;

  logic             sel_ok;
  logic             will_drop;
  logic             accept;
  logic [N-1:0]     first_mask;
  logic [N-1:0]     load_mask;

  always_comb begin
    sel_ok     = {1'b0, in_sel} < NUM_CH;
    first_mask = '0;
    if (in_bcast) begin
      first_mask = ALL_CH;
    end else if (sel_ok) begin
      first_mask = N'(1) << in_sel;
    end
    load_mask = (state_q == IDLE) ? first_mask : rmask_q;
    will_drop = (state_q == DROP) || ((state_q == IDLE) && !in_bcast && !sel_ok);
    // A forwarded beat may enter only if every pending channel completes now.
    in_ready  = will_drop || ((pend_q & ~out_ready) == '0);
    accept    = in_valid && in_ready;

    state_d    = state_q;
    rmask_d    = rmask_q;
    pend_d     = pend_q & ~out_ready;
    data_d     = data_q;
    last_d     = last_q;
    drop_cnt_d = drop_cnt_q;

    if (accept) begin
      if (will_drop) begin
        if ((state_q == IDLE) && (drop_cnt_q != {CW{1'b1}})) begin
          drop_cnt_d = drop_cnt_q + CW'(1);
        end
        state_d = in_last ? IDLE : DROP;
      end else begin
        pend_d  = load_mask;
        rmask_d = load_mask;
        data_d  = in_data;
        last_d  = in_last;
        state_d = in_last ? IDLE : FWD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q    <= IDLE;
      rmask_q    <= '0;
      pend_q     <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rmask_q    <= rmask_d;
      pend_q     <= pend_d;
      data_q     <= data_d;
      last_q     <= last_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign out_valid = pend_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign drop_cnt  = drop_cnt_q;
  assign busy      = (state_q != IDLE) || (pend_q != '0);

endmodule

// File: tb/tb_stream_demux.sv
// Randomised and directed bench for stream_demux (N=6 so that selects 6 and 7
// are nonexistent, CW=2 so drop-counter saturation is reachable).
module tb_stream_demux;

  localparam int WIDTH = 8;
  localparam int N     = 6;
  localparam int SW    = 3;
  localparam int CW    = 2;
  localparam int ALLM  = (1 << N) - 1;
  localparam int CMAX  = (1 << CW) - 1;

  logic             clk = 1'b0;
  logic             clrn;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic [SW-1:0]    in_sel;
  logic             in_bcast;
  logic [N-1:0]     out_valid;
  logic [N-1:0]     out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic [CW-1:0]    drop_cnt;
  logic             busy;

  stream_demux #(.WIDTH(WIDTH), .N(N), .SW(SW), .CW(CW)) dut (
    .clk(clk), .clrn(clrn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_sel(in_sel), .in_bcast(in_bcast),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference: route is -1 between packets, 0 while discarding, else the channel mask.
  int route  = -1;
  int m_pend = 0;
  int m_data = 0;
  int m_last = 0;
  int m_drops = 0;
  logic [8:0] expq [N][$];
  int stall [N];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive, check at the falling edge, advance the model on the rising edge.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l,
                               input logic [2:0] s, input logic b,
                               input logic [N-1:0] r, output logic acc);
    int mask;
    logic drop_now;
    logic exp_rdy;
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    in_sel    = s;
    in_bcast  = b;
    out_ready = r;
    @(negedge clk);
    drop_now = (route == 0) || ((route == -1) && !b && (int'(s) >= N));
    exp_rdy  = drop_now || ((m_pend & ~int'(r)) == 0);
    checkOutput("in_ready", 32'(in_ready), 32'(exp_rdy));
    checkOutput("out_valid", 32'(out_valid), m_pend);
    checkOutput("out_data", 32'(out_data), m_data);
    checkOutput("out_last", 32'(out_last), m_last);
    checkOutput("drop_cnt", 32'(drop_cnt), m_drops);
    checkOutput("busy", 32'(busy), 32'((route != -1) || (m_pend != 0)));
    if (clrn) begin
      for (int i = 0; i < N; i++) begin
        if (out_valid[i] && r[i]) begin
          if (expq[i].size() == 0) begin
            checkOutput($sformatf("sb_extra_ch%0d", i), 32'(out_valid[i]), 32'(0));
          end else begin
            checkOutput($sformatf("sb_ch%0d", i), 32'({out_last, out_data}), 32'(expq[i].pop_front()));
          end
        end
      end
    end
    acc = v && exp_rdy && clrn;
    @(posedge clk);
    if (!clrn) begin
      route = -1; m_pend = 0; m_data = 0; m_last = 0; m_drops = 0;
      for (int i = 0; i < N; i++) expq[i].delete();
    end else begin
      m_pend = m_pend & ~int'(r);
      if (acc) begin
        mask = route;
        if (route == -1) mask = b ? ALLM : ((int'(s) < N) ? (1 << s) : 0);
        if (mask == 0) begin
          if (route == -1 && m_drops < CMAX) m_drops++;
          route = l ? -1 : 0;
        end else begin
          m_pend = mask; m_data = d; m_last = l;
          for (int i = 0; i < N; i++) if (mask[i]) expq[i].push_back({l, d});
          route = l ? -1 : mask;
        end
      end
    end
    #1;
  endtask

  function automatic logic [N-1:0] readyFromStall();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (stall[i] == 0);
    return r;
  endfunction

  task automatic tickStall();
    for (int i = 0; i < N; i++) if (stall[i] > 0) stall[i]--;
  endtask

  task automatic sendBeat(input logic [7:0] d, input logic l, input logic [2:0] s, input logic b);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      applyStimulus(1'b1, d, l, s, b, readyFromStall(), acc);
      tickStall();
      n++;
    end
    if (!acc) begin
      total++; bad++;
      $display("[TB] FAIL accept_timeout: got=not accepted expected=accepted data=%0h", d);
    end
  endtask

  task automatic idleCycles(input int n);
    logic acc;
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, readyFromStall(), acc);
      tickStall();
    end
  endtask

  task automatic doReset();
    clrn = 1'b0;
    idleCycles(1);
    clrn = 1'b1;
  endtask

  initial begin
    logic acc;
    logic [2:0] csel [5];
    for (int i = 0; i < N; i++) stall[i] = 0;
    clrn = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    in_sel = '0; in_bcast = 1'b0; out_ready = '0;
    idleCycles(2);
    clrn = 1'b1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'(0));
    checkOutput("reset_drop_cnt", 32'(drop_cnt), 32'(0));

    // Unicast to channel 5 under backpressure
    stall[5] = 3;
    sendBeat(8'h11, 1'b0, 3'd5, 1'b0);
    sendBeat(8'h22, 1'b0, 3'd5, 1'b0);
    sendBeat(8'h33, 1'b1, 3'd5, 1'b0);
    idleCycles(3);

    // Broadcast with channel 0 late
    stall[0] = 4;
    sendBeat(8'hA5, 1'b1, 3'd0, 1'b1);
    checkOutput("bcast_all_pending", 32'(out_valid), 32'(ALLM));
    idleCycles(5);

    // Four-beat packet to a missing channel, then one to channel 2
    for (int k = 0; k < 4; k++) sendBeat(8'(8'h40 + k), (k == 3), 3'd7, 1'b0);
    checkOutput("drop_count_one", 32'(drop_cnt), 32'(1));
    sendBeat(8'h52, 1'b1, 3'd2, 1'b0);
    idleCycles(2);

    // Route lock: later beats carry select 4 but stay on channel 1
    for (int k = 0; k < 4; k++) sendBeat(8'(8'h60 + k), (k == 3), (k == 0) ? 3'd1 : 3'd4, 1'b0);
    for (int k = 0; k < 2; k++) sendBeat(8'(8'h70 + k), (k == 1), 3'd4, 1'b0);
    idleCycles(2);

    // Saturation of the drop counter
    doReset();
    for (int k = 0; k < 5; k++) begin
      sendBeat(8'hEE, 1'b1, (k % 2 == 0) ? 3'd6 : 3'd7, 1'b0);
      checkOutput($sformatf("sat_%0d", k), 32'(drop_cnt), 32'((k < CMAX) ? k + 1 : CMAX));
    end

    // Reset in the middle of a forwarded packet with a stalled beat
    stall[1] = 10;
    sendBeat(8'h81, 1'b0, 3'd1, 1'b0);
    sendBeat(8'h82, 1'b0, 3'd1, 1'b0);
    doReset();
    stall[1] = 0;
    checkOutput("midreset_out_valid", 32'(out_valid), 32'(0));
    checkOutput("midreset_drop_cnt", 32'(drop_cnt), 32'(0));
    sendBeat(8'h93, 1'b1, 3'd3, 1'b0);
    checkOutput("midreset_ch3", 32'(out_valid), 32'(1 << 3));
    idleCycles(2);

    // Random traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = ($urandom_range(0, 3) != 0);
      clrn = ($urandom_range(0, 299) != 0);
      applyStimulus($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 2) == 0,
                    3'($urandom_range(0, 7)), $urandom_range(0, 7) == 0, r, acc);
    end
    clrn = 1'b1;
    idleCycles(4);
    for (int i = 0; i < N; i++) checkOutput($sformatf("sb_left_ch%0d", i), 32'(expq[i].size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
# stream_demux

Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshaking on every port. Each packet is routed to one output channel (unicast) or to all channels (broadcast). The route is taken from the packet's first beat and held until its last beat. Packets addressed to a nonexistent channel are consumed, discarded and counted. The block sits between a single producer stream and N consumer streams, and is the handshaked, packet-aware successor of the combinational select-and-gate demultiplexer.

## Interface
- `WIDTH`, default 8: data width in bits.
- `N`, default 8: number of output channels, 2..2^`SW`.
- `SW`, default 3: select width in bits.
- `CW`, default 8: drop-counter width in bits.

- `clk`  in  1  clock; all logic on the rising edge.
- `clrn`  in  1  reset; synchronous, active-low.
- `in_valid`  in  1  producer beat valid.
- `in_ready`  out  1  block accepts the beat this cycle.
- `in_data`  in  `WIDTH`  beat payload.
- `in_last`  in  1  final beat of the packet.
- `in_sel`  in  `SW`  destination channel; sampled on the first beat only.
- `in_bcast`  in  1  broadcast request; sampled on the first beat only, overrides `in_sel`.
- `out_valid`  out  `N`  per-channel valid; bit i is channel i.
- `out_ready`  in  `N`  per-channel ready.
- `out_data`  out  `WIDTH`  shared payload bus for all channels.
- `out_last`  out  1  shared last flag.
- `drop_cnt`  out  `CW`  dropped-packet count, saturating.
- `busy`  out  1  state ≠ IDLE, or any `out_valid` bit set.

## Operation
- **Input transfer:** `in_valid & in_ready`. **Channel i transfer:** `out_valid[i] & out_ready[i]`.
- **Output stage:** one register holding data, last and a pending mask `pend[N-1:0]`, with `out_valid = pend`.
  - A channel transfer clears its `pend` bit.
  - The stage is empty when `pend == 0`.
- **States:**
  - IDLE: awaiting the first beat.
  - FWD: route locked to mask `rmask`.
  - DROP: discarding the current packet.
- **First beat, accepted in IDLE.** Route is chosen as follows:
  - `in_bcast=1` → `rmask = {N{1}}`.
  - `in_sel < N` → `rmask = 1 << in_sel`.
  - Otherwise the packet is dropped.
- **Forwarding a beat:** load data and last into the stage, set `pend = rmask` (computed or latched).
  - If `in_last=0`, go to FWD; otherwise stay in IDLE.
- **Dropping a packet:**
  - Beat is not loaded into the stage.
  - `drop_cnt` increments by 1 on the first beat, saturating at 2^`CW`-1.
  - If `in_last=0`, go to DROP.
- **FWD:**
  - `in_sel` and `in_bcast` are ignored; every accepted beat uses the latched `rmask`.
  - An accepted beat with `in_last=1` returns to IDLE.
- **DROP:**
  - Beats are accepted and discarded.
  - An accepted beat with `in_last=1` returns to IDLE.
  - The stage keeps draining independently.
- **`in_ready`:**
  - When the beat will be dropped (DROP, or IDLE with an invalid `in_sel` and no broadcast): 1.
  - Otherwise: `(pend & ~out_ready) == 0`, i.e. the stage is empty or every pending channel completes this cycle.
- **`in_ready` has no dependence on `in_valid`.** It depends combinationally on `out_ready`, and in IDLE on `in_sel`/`in_bcast`.
- **Broadcast:** the beat stays in the stage until every channel has transferred. Channels may accept in different cycles.
- **Simultaneous drain and load:** the last pending bits clearing and a new beat arriving in the same cycle gives `pend = rmask`. There is no bubble.

## Timing
- **Reset (`clrn=0` at a clock edge):**
  - State = IDLE.
  - `pend = 0`, so `out_valid = 0`.
  - `out_data = 0`, `out_last = 0`, `drop_cnt = 0`, `busy = 0`.
  - `rmask = 0`.
  - `in_ready` is combinational and may be 1 while in reset.
- **Reset mid-packet:** all state is discarded. The next accepted beat is treated as a first beat.
- **Latency:** an input accepted at edge k drives `out_valid` at edge k.
  - The beat is visible in the cycle after acceptance: 1-cycle latency.
- **Throughput:** with the target's `out_ready` held at 1, unicast sustains 1 beat/clock.
  - Broadcast sustains 1 beat/clock only if all `out_ready` are 1.
- **Output stability:** `out_data` and `out_last` are stable while any `pend` bit is set. A `pend` bit never drops without its transfer.
- **`drop_cnt` update:** changes on the edge that accepts the dropped packet's first beat.

## Test plan
- **Unicast with backpressure:** `N=8`, packet of 3 beats `0x11, 0x22, 0x33`, `in_sel=5`; `out_ready[5]` low for 2 cycles and then high.
  - Only `out_valid[5]` asserts; data arrives in order; `out_last` is set only with `0x33`.
  - `in_ready` is 0 while channel 5 stalls.
  - `busy` falls 1 cycle after the last transfer.
- **Broadcast:** `in_bcast=1`, single-beat packet `0xA5`; `out_ready[0]` is delayed 3 cycles, all other readies high.
  - `out_valid` goes `0xFF`, then `0x01`, then `0x00`.
  - `in_ready` returns to 1 in the cycle channel 0 transfers.
- **Drop:** `N=6`, `SW=3`, packet of 4 beats with `in_sel=7`, followed by a packet with `in_sel=2`.
  - All 4 beats are accepted in 4 cycles; `out_valid` stays 0; `drop_cnt = 1`.
  - The following packet appears on channel 2.
- **Route lock and full rate:** first beat with `in_sel=1`, later beats with `in_sel` toggling to 4; `out_ready` all high.
  - All beats go to channel 1, one per cycle with no bubbles.
  - Next packet with `in_sel=4` goes to channel 4, back-to-back.
- **Counter saturation:** `CW=2`, 5 dropped single-beat packets.
  - `drop_cnt` reads 1, 2, 3, 3, 3.
- **Reset mid-packet:** assert `clrn=0` for 1 cycle in FWD with `pend` set.
  - After reset: `out_valid = 0`, `drop_cnt = 0`.
  - Next beat with `in_sel=3` routes to channel 3.
